pwm_capture8b: RTL and testbench



---
 rtl/pwm_capture8b_pkg.sv | 18 +
 rtl/pwm_capture8b_if.sv | 31 +++
 rtl/pwm_capture8b_sync_ff.sv | 25 ++
 rtl/pwm_capture8b.sv | 135 +++++++++++++
 tb/tb_pwm_capture8b.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_capture8b_pkg.sv
// Shared definitions for the PWM duty-capture block: FSM state encoding,
// the 8-bit saturation limit and a saturating narrowing helper.
package pwm_capture8b_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [7:0] SAT_MAX = 8'd255;

    // Clamp a window sum into the 8-bit result range.
    function automatic logic [7:0] sat8(input logic [31:0] x);
        return (x > 32'(SAT_MAX)) ? SAT_MAX : x[7:0];
    endfunction

endpackage

// File: rtl/pwm_capture8b_if.sv
// Measurement-side signal bundle of the PWM duty-capture block.
// master: the logic driving enable/pin and consuming results.
// slave:  the capture block itself.
interface pwm_capture8b_if;

    logic       en;
    logic       pwm_in;
    logic [7:0] value_out;
    logic       valid;
    logic       full_high;
    logic       locked;

    modport master (
        output en,
        output pwm_in,
        input  value_out,
        input  valid,
        input  full_high,
        input  locked
    );

    modport slave (
        input  en,
        input  pwm_in,
        output value_out,
        output valid,
        output full_high,
        output locked
    );

endinterface

// File: rtl/pwm_capture8b_sync_ff.sv
// Parameterized flop chain for bringing an asynchronous pin into the clk
// domain. Synchronous active-low reset clears every stage.
module pwm_capture8b_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pin value one stage deeper every clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_capture8b.sv
// Recovers the 8-bit duty value of a 256-clock-period PWM input by counting
// high samples over back-to-back windows of 2**WIN_BITS clocks. Each result
// is published with a one-cycle valid strobe; locked reports that the last
// LOCK_COUNT window sums were identical.
module pwm_capture8b
    import pwm_capture8b_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIN_BITS    = 8,
    parameter int unsigned LOCK_COUNT  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_capture8b_if.slave bus
);

    localparam int unsigned SUM_W = WIN_BITS + 1;
    localparam int unsigned MC_W  = $clog2(LOCK_COUNT);

    // Settle spans the synchronizer depth twice: once for the chain to fill
    // with live pin samples, once more so the first measured sample is clean.
    localparam logic [WIN_BITS-1:0] SETTLE_LAST = WIN_BITS'(2 * SYNC_STAGES - 1);
    localparam logic [SUM_W-1:0]    FULL_SUM    = {1'b1, {WIN_BITS{1'b0}}};
    localparam logic [MC_W-1:0]     LOCK_LAST   = MC_W'(LOCK_COUNT - 1);

    logic                s;
    state_t              state;
    logic [WIN_BITS-1:0] win_cnt;
    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    prev_sum;
    logic [SUM_W-1:0]    sum;
    logic [MC_W-1:0]     match_cnt;
    logic [MC_W-1:0]     match_nxt;

    logic [7:0]          value_q;
    logic                valid_q;
    logic                full_high_q;
    logic                locked_q;

    pwm_capture8b_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pwm_in),
        .q     (s)
    );

    // Running window total including the current sample.
    always_comb begin
        sum = acc + SUM_W'(s);
    end

    // Consecutive-match counter as it would be after this window closes.
    always_comb begin
        match_nxt = '0;
        if (sum == prev_sum) begin
            if (match_cnt == LOCK_LAST) begin
                match_nxt = match_cnt;
            end else begin
                match_nxt = match_cnt + MC_W'(1);
            end
        end
    end

    // Capture FSM: idle, flush the synchronizer, then measure windows
    // back to back, registering each result at the window's last sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_cnt     <= '0;
            acc         <= '0;
            prev_sum    <= '0;
            match_cnt   <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            full_high_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.en) begin
                // Abort: partial window discarded, results held, lock lost.
                state     <= IDLE;
                win_cnt   <= '0;
                acc       <= '0;
                match_cnt <= '0;
                locked_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        win_cnt  <= '0;
                        acc      <= '0;
                        // Unreachable sum value, so the first window never matches.
                        prev_sum <= '1;
                        state    <= SETTLE;
                    end
                    SETTLE: begin
                        acc <= '0;
                        if (win_cnt == SETTLE_LAST) begin
                            win_cnt <= '0;
                            state   <= MEASURE;
                        end else begin
                            win_cnt <= win_cnt + WIN_BITS'(1);
                        end
                    end
                    MEASURE: begin
                        win_cnt <= win_cnt + WIN_BITS'(1);
                        if (win_cnt == '1) begin
                            acc         <= '0;
                            valid_q     <= 1'b1;
                            value_q     <= sat8(32'(sum));
                            full_high_q <= (sum == FULL_SUM);
                            match_cnt   <= match_nxt;
                            locked_q    <= (match_nxt == LOCK_LAST);
                            prev_sum    <= sum;
                        end else begin
                            acc <= sum;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        win_cnt <= '0;
                        acc     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.value_out = value_q;
    assign bus.valid     = valid_q;
    assign bus.full_high = full_high_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_pwm_capture8b.sv
// Directed bench for pwm_capture8b. A pwm8b-style generator drives the pin;
// expected window results are queued as stimulus is set up and a monitor
// pops and compares them on each valid strobe.
module tb_pwm_capture8b;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pwm_capture8b_if bus();

    pwm_capture8b #(
        .SYNC_STAGES (2),
        .WIN_BITS    (8),
        .LOCK_COUNT  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int    lo;
        int    hi;
        logic  fh;
        logic  lk;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Pin generator controls: 0 = PWM of pwm_v, 1 = held high, 2 = held low.
    int pwm_mode  = 0;
    int pwm_v     = 10;
    int pwm_phase = 0;
    int pwm_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int lo, input int hi, input logic fh, input logic lk, input string tag);
        exp_t e;
        e.lo  = lo;
        e.hi  = hi;
        e.fh  = fh;
        e.lk  = lk;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Count rising edges until valid is seen just after one; bounded by budget.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (bus.valid !== 1'b1 && n < budget);
    endtask

    // pwm8b model: high while its free-running counter is below pwm_v.
    initial begin
        bus.pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            pwm_cnt = (pwm_cnt + 1) % 256;
            case (pwm_mode)
                1:       bus.pwm_in = 1'b1;
                2:       bus.pwm_in = 1'b0;
                default: bus.pwm_in = (((pwm_cnt + pwm_phase) % 256) < pwm_v);
            endcase
        end
    end

    // Scoreboard monitor: every valid strobe consumes one expected result.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.valid === 1'b1) begin
                chk("valid_not_back_to_back", 32'(prev_valid), 32'd0);
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL unexpected_valid: got value_out=%0d with nothing expected", bus.value_out);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert ((int'(bus.value_out) >= e.lo) && (int'(bus.value_out) <= e.hi))
                    else begin
                        errors++;
                        $error("FAIL %s_value: got %0d expected %0d..%0d", e.tag, bus.value_out, e.lo, e.hi);
                    end
                    chk({e.tag, "_full_high"}, 32'(bus.full_high), 32'(e.fh));
                    chk({e.tag, "_locked"}, 32'(bus.locked), 32'(e.lk));
                end
            end
            prev_valid = bus.valid;
        end
    end

    initial begin
        int n;
        int sweep_v[5];
        sweep_v = '{0, 1, 128, 254, 255};

        // Reset state.
        rst_n  = 1'b0;
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value_out", 32'(bus.value_out), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_full_high", 32'(bus.full_high), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);

        // v=10, enable together with reset release.
        push(10, 10, 1'b0, 1'b0, "v10_first");
        push(10, 10, 1'b0, 1'b1, "v10_second");
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        wait_valid(300, n);
        chk("v10_first_latency", 32'(n), 32'd261);
        wait_valid(300, n);
        chk("v10_second_gap", 32'(n), 32'd256);

        // Drop en for one cycle at win_cnt=100 of a locked window.
        repeat (100) @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_locked", 32'(bus.locked), 32'd0);
        chk("abort_value_hold", 32'(bus.value_out), 32'd10);
        chk("abort_no_valid", 32'(bus.valid), 32'd0);
        push(10, 10, 1'b0, 1'b0, "reen_first");
        push(10, 10, 1'b0, 1'b1, "reen_second");
        @(negedge clk);
        bus.en = 1'b1;
        wait_valid(300, n);
        chk("reen_latency", 32'(n), 32'd261);
        wait_valid(300, n);
        chk("reen_gap", 32'(n), 32'd256);

        // Change v from 10 to 200 mid-window.
        repeat (128) @(posedge clk);
        push(11, 199, 1'b0, 1'b0, "chg_transition");
        push(200, 200, 1'b0, 1'b0, "chg_200_first");
        push(200, 200, 1'b0, 1'b1, "chg_200_second");
        @(negedge clk);
        pwm_v = 200;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("chg_gap1", 32'(n), 32'd256);
        wait_valid(300, n);
        chk("chg_gap2", 32'(n), 32'd256);

        // Duty sweep with random phase offsets; each run restarts measurement.
        foreach (sweep_v[i]) begin
            @(negedge clk);
            bus.en    = 1'b0;
            pwm_mode  = 0;
            pwm_v     = sweep_v[i];
            pwm_phase = int'($urandom_range(0, 255));
            push(sweep_v[i], sweep_v[i], 1'b0, 1'b0, $sformatf("sweep%0d_a", sweep_v[i]));
            push(sweep_v[i], sweep_v[i], 1'b0, 1'b1, $sformatf("sweep%0d_b", sweep_v[i]));
            @(negedge clk);
            bus.en = 1'b1;
            wait_valid(300, n);
            chk($sformatf("sweep%0d_latency", sweep_v[i]), 32'(n), 32'd261);
            wait_valid(300, n);
            chk($sformatf("sweep%0d_gap", sweep_v[i]), 32'(n), 32'd256);
        end

        // Constant high, then constant low.
        for (int m = 1; m <= 2; m++) begin
            @(negedge clk);
            bus.en   = 1'b0;
            pwm_mode = m;
            if (m == 1) begin
                push(255, 255, 1'b1, 1'b0, "const_hi_a");
                push(255, 255, 1'b1, 1'b1, "const_hi_b");
            end else begin
                push(0, 0, 1'b0, 1'b0, "const_lo_a");
                push(0, 0, 1'b0, 1'b1, "const_lo_b");
            end
            @(negedge clk);
            bus.en = 1'b1;
            wait_valid(300, n);
            chk("const_latency", 32'(n), 32'd261);
            wait_valid(300, n);
        end

        // Reach lock on v=10, then reset mid-window.
        @(negedge clk);
        bus.en    = 1'b0;
        pwm_mode  = 0;
        pwm_v     = 10;
        pwm_phase = 0;
        push(10, 10, 1'b0, 1'b0, "prerst_a");
        push(10, 10, 1'b0, 1'b1, "prerst_b");
        @(negedge clk);
        bus.en = 1'b1;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("prerst_locked", 32'(bus.locked), 32'd1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_value_out", 32'(bus.value_out), 32'd0);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        chk("midrst_full_high", 32'(bus.full_high), 32'd0);
        chk("midrst_locked", 32'(bus.locked), 32'd0);
        push(10, 10, 1'b0, 1'b0, "postrst_a");
        push(10, 10, 1'b0, 1'b1, "postrst_b");
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(300, n);
        chk("postrst_latency", 32'(n), 32'd261);
        wait_valid(300, n);
        chk("postrst_gap", 32'(n), 32'd256);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
